bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL provide parameter NREQ, default 4, number of requesters (2..8).
REQ-003 The block SHALL provide parameter MAX_BURST, default 4, maximum consecutive grants to one locked requester (1..15).
REQ-004 The block SHALL provide port clock  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL provide port clear  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL provide port req  input  NREQ  per-requester write request.
REQ-007 The block SHALL provide port lock  input  NREQ  per-requester burst hold, valid only with req.
REQ-008 The block SHALL provide port op_clr  input  NREQ  per-requester clear operation instead of write.
REQ-009 The block SHALL provide port dest  input  NREQ*4  per-requester destination register index 0..15, requester i at bits [4i+3:4i].
REQ-010 The block SHALL provide port wdata  input  NREQ*DATA_WIDTH  per-requester write data, requester i at slice i.
REQ-011 The block SHALL provide port gnt  output  NREQ  one-hot grant, registered.
REQ-012 The block SHALL provide port reg_enable  output  16  one-hot register write enable, registered.
REQ-013 The block SHALL provide port reg_clear  output  16  one-hot register clear, registered.
REQ-014 The block SHALL provide port reg_data  output  DATA_WIDTH  data for the enabled register, registered.
REQ-015 The block SHALL provide port busy  output  1  high while state is XFER.

Function
REQ-016 States: IDLE (no grant in current cycle), XFER (exactly one gnt bit high in current cycle).
REQ-017 Each rising edge: eligible set = req bits, minus the requester whose gnt is high unless its lock is high and burst count < MAX_BURST.
REQ-018 Eligible set non-empty -> next state XFER; winner = first eligible index searching upward from rr_ptr, wrapping NREQ-1 -> 0.
REQ-019 Eligible set empty -> next state IDLE; gnt, reg_enable, reg_clear, reg_data all zero next cycle.
REQ-020 Latency: request sampled at edge E; gnt, reg_enable/reg_clear, reg_data valid in cycle after E (1 cycle).
REQ-021 Winner with op_clr=0: reg_enable = one-hot(dest of winner), reg_clear = 0, reg_data = wdata of winner captured at E.
REQ-022 Winner with op_clr=1: reg_clear = one-hot(dest of winner), reg_enable = 0, reg_data = 0.
REQ-023 At most one bit of reg_enable|reg_clear SHALL be high in any cycle; gnt bit count SHALL be 0 or 1.
REQ-024 rr_ptr updates to (winner+1) mod NREQ on every grant; unchanged in IDLE.
REQ-025 Burst count: set to 1 on grant to a new requester; incremented on re-grant of same requester; cleared in IDLE.
REQ-026 Burst count reaching MAX_BURST SHALL exclude that requester at the next edge even with lock high; other requesters win if eligible, else IDLE.
REQ-027 Handshake: requester treats gnt-high cycle as acceptance; item presented during that cycle is its next item.
REQ-028 Re-grant of locked requester SHALL be back-to-back (no IDLE cycle) while its req and lock stay high and count < MAX_BURST.
REQ-029 lock without req SHALL be ignored; inputs of non-winning requesters SHALL not affect outputs.

Reset
REQ-030 clear low SHALL immediately force state IDLE, gnt=0, reg_enable=0, reg_clear=0, reg_data=0, busy=0, rr_ptr=0, burst count=0.
REQ-031 Reset asserted mid-XFER SHALL abort the grant in the same cycle; first arbitration occurs at first rising edge with clear high.

Verification
REQ-032 Reset release, req=4'b0000 -> gnt=0, reg_enable=0, busy=0 for 5 cycles.
REQ-033 req=4'b0101 continuously, lock=0, dest0=3, dest2=7 -> gnt alternates 0001,0100,0001,...; reg_enable alternates bit3, bit7.
REQ-034 req[1]=1, lock[1]=1, MAX_BURST=4, req[3]=1 -> gnt=0010 for 4 consecutive cycles, then 1000, then 0010.
REQ-035 req[2]=1, op_clr[2]=1, dest2=12, wdata2=32'hDEADBEEF -> reg_clear=bit12, reg_enable=0, reg_data=0 one cycle later.
REQ-036 req[0]=1, wdata0=32'h0000_00A5, dest0=5 -> next cycle reg_enable=16'h0020, reg_data=32'h0000_00A5, gnt=0001.
REQ-037 clear driven low mid-burst between edges -> all outputs 0 before next edge; after release, winner from rr_ptr=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that turns one requester's write/clear request per cycle
// into registered one-hot register-file strobes, with lock-based burst hold.
module bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            lock,
  input  logic [NREQ-1:0]            op_clr,
  input  logic [NREQ*4-1:0]          dest,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [15:0]                reg_enable,
  output logic [15:0]                reg_clear,
  output logic [DATA_WIDTH-1:0]      reg_data,
  output logic                       busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e                state_q;
  logic [NREQ-1:0]       gnt_q;
  logic [15:0]           reg_enable_q;
  logic [15:0]           reg_clear_q;
  logic [DATA_WIDTH-1:0] reg_data_q;
  logic [PW-1:0]         owner_q;
  logic [PW-1:0]         rr_ptr_q;
  logic [3:0]            burst_q;

  logic                  hold;
  logic [NREQ-1:0]       elig;
  logic                  found;
  logic [PW-1:0]         win;
  logic [PW-1:0]         idx;
  int                    t;
  logic [3:0]            w_dest;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_clr;
  logic [PW-1:0]         rr_ptr_d;
  logic [3:0]            burst_d;

  // A locked owner under its burst limit keeps the bus ahead of the rotation.
  always_comb begin
    hold  = 1'b0;
    elig  = req;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    t     = 0;
    if (state_q == XFER) begin
      hold = req[owner_q] && lock[owner_q] && (burst_q < 4'(MAX_BURST));
      if (!hold) elig[owner_q] = 1'b0;
    end
    if (hold) begin
      found = 1'b1;
      win   = owner_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        t = int'(rr_ptr_q) + k;
        if (t >= NREQ) t = t - NREQ;
        idx = PW'(t);
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  always_comb begin
    w_dest = '0;
    w_data = '0;
    w_clr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        w_dest = dest[i*4 +: 4];
        w_data = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_clr  = op_clr[i];
      end
    end
    rr_ptr_d = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
    burst_d  = ((state_q == XFER) && (win == owner_q)) ? burst_q + 4'd1 : 4'd1;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      reg_enable_q <= '0;
      reg_clear_q  <= '0;
      reg_data_q   <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_q      <= '0;
    end else if (found) begin
      state_q      <= XFER;
      gnt_q        <= NREQ'(1) << win;
      reg_enable_q <= w_clr ? 16'h0000 : (16'h0001 << w_dest);
      reg_clear_q  <= w_clr ? (16'h0001 << w_dest) : 16'h0000;
      reg_data_q   <= w_clr ? '0 : w_data;
      owner_q      <= win;
      rr_ptr_q     <= rr_ptr_d;
      burst_q      <= burst_d;
    end else begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      reg_enable_q <= '0;
      reg_clear_q  <= '0;
      reg_data_q   <= '0;
      burst_q      <= '0;
    end
  end

  assign gnt        = gnt_q;
  assign reg_enable = reg_enable_q;
  assign reg_clear  = reg_clear_q;
  assign reg_data   = reg_data_q;
  assign busy       = (state_q == XFER);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then random traffic, every cycle
// compared against a behavioural arbitration model kept in the bench.
module tb_bus_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clock = 1'b0;
  logic            clear;
  logic [NR-1:0]   req, lock, op_clr;
  logic [NR*4-1:0] dest;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]   gnt;
  logic [15:0]     reg_enable, reg_clear;
  logic [DW-1:0]   reg_data;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  // model state: current owner (-1 = none), burst length, rotation pointer
  int m_owner, m_burst, m_ptr;
  logic [NR-1:0] e_gnt;
  logic [15:0]   e_en, e_clr;
  logic [DW-1:0] e_data;

  bus_arbiter #(.DATA_WIDTH(DW), .NREQ(NR), .MAX_BURST(MB)) dut (
    .clock(clock), .clear(clear), .req(req), .lock(lock), .op_clr(op_clr),
    .dest(dest), .wdata(wdata), .gnt(gnt), .reg_enable(reg_enable),
    .reg_clear(reg_clear), .reg_data(reg_data), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_burst = 0; m_ptr = 0;
    e_gnt = '0; e_en = '0; e_clr = '0; e_data = '0;
  endtask

  // Rules: a locked owner below the burst limit keeps the bus; otherwise the
  // owner sits out and the first requester at or after the pointer wins.
  task automatic model_edge();
    int w;
    logic [3:0] d;
    w = -1;
    if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_burst < MB) w = m_owner;
    else
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (w < 0 && req[c] && c != m_owner) w = c;
      end
    if (w < 0) begin
      m_owner = -1; m_burst = 0;
      e_gnt = '0; e_en = '0; e_clr = '0; e_data = '0;
    end else begin
      m_burst = (w == m_owner) ? m_burst + 1 : 1;
      m_owner = w;
      m_ptr   = (w + 1) % NR;
      d       = dest[4*w +: 4];
      e_gnt   = '0;
      e_gnt[w] = 1'b1;
      e_en = '0; e_clr = '0; e_data = '0;
      if (op_clr[w]) e_clr[d] = 1'b1;
      else begin
        e_en[d] = 1'b1;
        e_data  = wdata[DW*w +: DW];
      end
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".gnt"},  64'(gnt),        64'(e_gnt));
    chk({tag, ".en"},   64'(reg_enable), 64'(e_en));
    chk({tag, ".clr"},  64'(reg_clear),  64'(e_clr));
    chk({tag, ".data"}, 64'(reg_data),   64'(e_data));
    chk({tag, ".busy"}, 64'(busy),       64'(e_gnt != '0));
    chk({tag, ".onehot_reg"}, 64'($countones(reg_enable | reg_clear) <= 1), 64'(1));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_out(tag);
  endtask

  task automatic zero_inputs();
    req = '0; lock = '0; op_clr = '0; dest = '0; wdata = '0;
  endtask

  initial begin
    zero_inputs();
    clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_out("reset");
    clear = 1'b1;

    for (int i = 0; i < 5; i++) step("idle_after_reset");

    req = 4'b0001; dest[3:0] = 4'd5; wdata[31:0] = 32'h0000_00A5;
    step("single_write");
    chk("single_write.gnt_const",  64'(gnt),        64'h1);
    chk("single_write.en_const",   64'(reg_enable), 64'h0020);
    chk("single_write.data_const", 64'(reg_data),   64'hA5);
    req = '0;
    step("back_to_idle");

    req = 4'b0101; dest[3:0] = 4'd3; dest[11:8] = 4'd7;
    wdata[95:64] = 32'h1234_5678;
    for (int i = 0; i < 6; i++) step("alternate");
    req = '0;
    step("idle_gap");

    req = 4'b1010; lock = 4'b0010; dest[7:4] = 4'd1; dest[15:12] = 4'd15;
    wdata[63:32] = 32'hAAAA_0001; wdata[127:96] = 32'hBBBB_0003;
    for (int i = 0; i < 4; i++) begin
      step("burst_hold");
      chk("burst_hold.gnt_const", 64'(gnt), 64'h2);
    end
    step("burst_limit");
    chk("burst_limit.gnt_const", 64'(gnt), 64'h8);
    step("burst_return");
    chk("burst_return.gnt_const", 64'(gnt), 64'h2);
    zero_inputs();
    step("idle_gap2");

    req = 4'b0100; op_clr = 4'b0100; dest[11:8] = 4'd12; wdata[95:64] = 32'hDEAD_BEEF;
    step("clear_op");
    chk("clear_op.clr_const",  64'(reg_clear),  64'h1000);
    chk("clear_op.en_const",   64'(reg_enable), 64'h0);
    chk("clear_op.data_const", 64'(reg_data),   64'h0);
    zero_inputs();
    step("idle_gap3");

    req = 4'b0010; lock = 4'b0010; dest[7:4] = 4'd9; wdata[63:32] = 32'h0BAD_F00D;
    step("pre_reset_burst");
    step("pre_reset_burst");
    clear = 1'b0;
    #1;
    model_reset();
    check_out("async_reset");
    @(posedge clock);
    @(negedge clock);
    check_out("held_reset");
    clear = 1'b1;
    req = 4'b1111; lock = '0;
    step("post_reset_first");
    chk("post_reset_first.gnt_const", 64'(gnt), 64'h1);

    for (int i = 0; i < 400; i++) begin
      req    = NR'($urandom_range(0, 15));
      lock   = NR'($urandom_range(0, 15));
      op_clr = ($urandom_range(0, 3) == 0) ? NR'($urandom_range(0, 15)) : '0;
      dest   = NR*4'($urandom);
      for (int j = 0; j < NR; j++) wdata[DW*j +: DW] = $urandom;
      if ($urandom_range(0, 60) == 0) begin
        clear = 1'b0;
        #1;
        model_reset();
        check_out("rand_reset");
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
      end else begin
        step("random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
